// File: rtl/mem_data_responder_if.sv
// Request/response bundle between the MEM stage and the data responder.
// The master issues accesses; the slave answers with one response strobe.
interface mem_data_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_dmtype;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_dmtype,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_dmtype,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mem_data_responder.sv
// MEM-stage data responder: one byte/half/word access per request into a
// little-endian word array, answered after a fixed latency.
module mem_data_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic                 clk,
    input logic                 rst,
    mem_data_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          we;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [2:0]    dmtype;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [31:0]   ldata;
    logic [31:0]   wrep;
    logic [31:0]   wmerged;
    logic [3:0]    be;
    logic          oor;
    logic          misal;
    logic          illegal;
    logic          err;
    logic          go_resp;
    logic          commit;

    assign idx     = addr[AW+1:2];
    assign lane    = addr[1:0];
    assign word    = mem[idx];
    assign shifted = word >> {lane, 3'b000};
    assign oor     = |addr[31:AW+2];
    assign err     = oor | misal | illegal;
    assign go_resp = (state == WAIT) && (cnt == 4'd0);
    assign commit  = go_resp && we && !err;

    always_comb begin
        misal   = 1'b0;
        illegal = 1'b0;
        ldata   = shifted;
        be      = 4'b1111;
        wrep    = wdata;
        unique case (dmtype)
            3'b000: misal = (lane != 2'b00);
            3'b001, 3'b010: begin
                misal = lane[0];
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wrep  = {2{wdata[15:0]}};
                ldata = {{16{shifted[15] & ~dmtype[1]}}, shifted[15:0]};
            end
            3'b011, 3'b100: begin
                be    = 4'b0001 << lane;
                wrep  = {4{wdata[7:0]}};
                ldata = {{24{shifted[7] & ~dmtype[2]}}, shifted[7:0]};
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        wmerged = word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wmerged[8*i +: 8] = wrep[8*i +: 8];
        end
    end

    // The array has no reset; aborted requests never reach commit.
    always_ff @(posedge clk) begin
        if (commit) mem[idx] <= wmerged;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            we            <= 1'b0;
            addr          <= 32'd0;
            wdata         <= 32'd0;
            dmtype        <= 3'd0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
            unique case (state)
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state         <= RESP;
                        bus.req_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= err;
                        bus.rsp_rdata <= (err || we) ? 32'd0 : ldata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    if (bus.req_valid) begin
                        state         <= WAIT;
                        we            <= bus.req_we;
                        addr          <= bus.req_addr;
                        wdata         <= bus.req_wdata;
                        dmtype        <= bus.req_dmtype;
                        cnt           <= 4'(LATENCY - 1);
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_data_responder.sv
// Bench for mem_data_responder: directed vectors, randomized traffic
// against a byte-array model, back-to-back and mid-operation reset.
module tb_mem_data_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_data_responder_if b2 ();
    mem_data_responder_if b1 ();
    mem_data_responder_if b4 ();

    mem_data_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) d2 (
        .clk(clk), .rst(rst), .bus(b2.slave));
    mem_data_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) d1 (
        .clk(clk), .rst(rst), .bus(b1.slave));
    mem_data_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) d4 (
        .clk(clk), .rst(rst), .bus(b4.slave));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  dmt;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] rd;
    } b2b_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] mm [4096];
    bit         known [4096];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, size and alignment by arithmetic.
    task automatic mdl(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] dmt,
                       output logic [31:0] rd, output logic er,
                       output bit kn);
        int size;
        logic [31:0] v;
        size = (dmt == 3'd0) ? 4 : (dmt <= 3'd2) ? 2 : 1;
        er = (dmt > 3'd4) || (addr >= 32'd4096) || (addr % size != 0);
        rd = 32'd0;
        kn = 1'b1;
        if (er) return;
        if (we) begin
            for (int k = 0; k < size; k++) begin
                mm[addr + k]    = wdata[8*k +: 8];
                known[addr + k] = 1'b1;
            end
        end else begin
            v = 32'd0;
            for (int k = 0; k < size; k++) begin
                v = v | ({24'd0, mm[addr + k]} << (8 * k));
                kn = kn & known[addr + k];
            end
            if (size < 4 && (dmt == 3'd1 || dmt == 3'd3) && v[8*size-1])
                v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
        end
    endtask

    task automatic txn2(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] dmt,
                        output logic [31:0] rd, output logic er,
                        output int lat, output bit busy_ok);
        lat = -1;
        rd = 32'd0;
        er = 1'b0;
        busy_ok = 1'b1;
        @(negedge clk);
        chk("ready_before_req", 32'(b2.req_ready), 32'd1);
        b2.req_valid  = 1'b1;
        b2.req_we     = we;
        b2.req_addr   = addr;
        b2.req_wdata  = wdata;
        b2.req_dmtype = dmt;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) b2.req_valid = 1'b0;
            if (b2.rsp_valid) begin
                lat = n;
                rd = b2.rsp_rdata;
                er = b2.rsp_err;
                if (b2.busy) busy_ok = 1'b0;
                break;
            end
            if (!b2.busy || b2.req_ready) busy_ok = 1'b0;
        end
    endtask

    vec_t        tbl [$];
    b2b_t        bq [$];
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          bok;
    logic [31:0] mrd;
    logic        mer;
    bit          mkn;
    logic [31:0] a;
    logic [2:0]  t;
    logic [31:0] shadow;
    b2b_t        e;
    int          last_acc;
    int          acc_n;
    int          rsp_n;
    bit          pend;
    int          got;
    bit          seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        b2.req_valid = 0; b2.req_we = 0; b2.req_addr = 0;
        b2.req_wdata = 0; b2.req_dmtype = 0;
        b1.req_valid = 0; b1.req_we = 0; b1.req_addr = 0;
        b1.req_wdata = 0; b1.req_dmtype = 0;
        b4.req_valid = 0; b4.req_we = 0; b4.req_addr = 0;
        b4.req_wdata = 0; b4.req_dmtype = 0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(b2.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        chk("rst_rdata", b2.rsp_rdata, 32'd0);
        chk("rst_err", 32'(b2.rsp_err), 32'd0);
        chk("rst_busy", 32'(b2.busy), 32'd0);
        chk("rst_ready_l1", 32'(b1.req_ready), 32'd1);
        chk("rst_busy_l4", 32'(b4.busy), 32'd0);
        rst = 1'b1;

        tbl.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 3'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0, 3'd0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h13, 32'h0, 3'd3, 32'hFFFFFFDE, 1'b0});
        tbl.push_back('{1'b0, 32'h13, 32'h0, 3'd4, 32'h000000DE, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0, 3'd1, 32'hFFFFBEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h12, 32'h0, 3'd2, 32'h0000DEAD, 1'b0});
        tbl.push_back('{1'b1, 32'h11, 32'h12345678, 3'd3, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0, 3'd0, 32'hDEAD78EF, 1'b0});
        tbl.push_back('{1'b1, 32'h12, 32'h0000CAFE, 3'd1, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0, 3'd0, 32'hCAFE78EF, 1'b0});
        tbl.push_back('{1'b0, 32'h11, 32'h0, 3'd0, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h13, 32'h0, 3'd1, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 32'h0, 32'h600DF00D, 3'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b1, 32'h1000, 32'h11111111, 3'd0, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h0, 32'h0, 3'd0, 32'h600DF00D, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0, 3'd6, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 32'h11, 32'hFFFFFFFF, 3'd2, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 32'h10, 32'hFFFFFFFF, 3'd7, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h10, 32'h0, 3'd0, 32'hCAFE78EF, 1'b0});

        foreach (tbl[i]) begin
            txn2(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].dmt,
                 rd, er, lat, bok);
            mdl(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].dmt,
                mrd, mer, mkn);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        end

        for (int w = 0; w < 16; w++) begin
            a = 32'(w * 4);
            shadow = $urandom;
            txn2(1'b1, a, shadow, 3'd0, rd, er, lat, bok);
            mdl(1'b1, a, shadow, 3'd0, mrd, mer, mkn);
        end

        for (int i = 0; i < 300; i++) begin
            got = int'($urandom_range(0, 9));
            if (got == 0) a = $urandom;
            else if (got == 1) a = 32'h1000 + 32'($urandom_range(0, 15));
            else a = 32'($urandom_range(0, 63));
            t = 3'($urandom_range(0, 7));
            shadow = $urandom;
            e.we = 1'($urandom_range(0, 1));
            txn2(e.we, a, shadow, t, rd, er, lat, bok);
            mdl(e.we, a, shadow, t, mrd, mer, mkn);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("rnd%0d_busy", i), 32'(bok), 32'd1);
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(mer));
            if (mkn) chk($sformatf("rnd%0d_rdata", i), rd, mrd);
        end

        @(negedge clk);
        b1.req_valid  = 1'b1;
        b1.req_we     = 1'b1;
        b1.req_addr   = 32'h20;
        b1.req_dmtype = 3'd0;
        b1.req_wdata  = $urandom;
        shadow = 32'd0;
        last_acc = -1;
        acc_n = 0;
        rsp_n = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 36; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (b1.rsp_valid) begin
                rsp_n++;
                chk("b2b_busy_in_resp", 32'(b1.busy), 32'd0);
                chk("b2b_err", 32'(b1.rsp_err), 32'd0);
                if (bq.size() == 0) begin
                    chk("b2b_unexpected_rsp", 32'd1, 32'(bq.size()));
                end else begin
                    e = bq.pop_front();
                    chk($sformatf("b2b_rdata_c%0d", cyc), b1.rsp_rdata, e.rd);
                end
            end
            if (pend) begin
                b1.req_we = ~b1.req_we;
                if (b1.req_we) b1.req_wdata = $urandom;
                pend = 1'b0;
            end
            if (cyc < 30) begin
                if (b1.req_ready) begin
                    if (last_acc >= 0)
                        chk("b2b_interval", 32'(cyc - last_acc), 32'd2);
                    last_acc = cyc;
                    acc_n++;
                    if (b1.req_we) shadow = b1.req_wdata;
                    e.we = b1.req_we;
                    e.rd = b1.req_we ? 32'd0 : shadow;
                    bq.push_back(e);
                    pend = 1'b1;
                end
            end else begin
                b1.req_valid = 1'b0;
            end
        end
        chk("b2b_accepts", 32'(acc_n), 32'd15);
        chk("b2b_responses", 32'(rsp_n), 32'd15);
        chk("b2b_drained", 32'(bq.size()), 32'd0);

        @(negedge clk);
        b4.req_valid  = 1'b1;
        b4.req_we     = 1'b1;
        b4.req_addr   = 32'h30;
        b4.req_wdata  = 32'h55555555;
        b4.req_dmtype = 3'd0;
        @(posedge clk);
        got = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) b4.req_valid = 1'b0;
            if (b4.rsp_valid) begin got = n; break; end
        end
        chk("l4_lat", 32'(got), 32'd5);

        @(negedge clk);
        b4.req_valid = 1'b1;
        b4.req_wdata = 32'hAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        b4.req_valid = 1'b0;
        seen = b4.rsp_valid;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_busy_before_rst", 32'(b4.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(b4.req_ready), 32'd1);
        chk("mid_rst_busy", 32'(b4.busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(b4.rsp_valid), 32'd0);
        chk("mid_rst_rdata", b4.rsp_rdata, 32'd0);
        chk("mid_rst_err", 32'(b4.rsp_err), 32'd0);
        repeat (2) begin
            @(negedge clk);
            if (b4.rsp_valid) seen = 1'b1;
        end
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (b4.rsp_valid) seen = 1'b1;
        end
        chk("mid_no_rsp", 32'(seen), 32'd0);

        b4.req_valid  = 1'b1;
        b4.req_we     = 1'b0;
        b4.req_addr   = 32'h30;
        b4.req_dmtype = 3'd0;
        @(posedge clk);
        got = -1;
        rd = 32'd0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) b4.req_valid = 1'b0;
            if (b4.rsp_valid) begin got = n; rd = b4.rsp_rdata; break; end
        end
        chk("mid_lw_lat", 32'(got), 32'd5);
        chk("mid_lw_rdata", rd, 32'h55555555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
